dram_line_responder: RTL and testbench

- Memory-side responder for the L1 cache's line-fill/write-back interface.
- Accepts one 256-bit line read or write per request over the cs/we/ack handshake.
- Models fixed access latency and returns a one-cycle ack.
- Sits between the L1 cache's external-memory port and the line storage array; used as the DRAM in system simulation and as the handshake endpoint in the cache testbench.

---
 rtl/dram_pkg.sv | 23 ++
 rtl/dram_line_storage.sv | 28 ++
 rtl/dram_line_responder.sv | 136 +++++++++++++
 tb/tb_dram_line_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types and sizing helpers for the DRAM line responder.
package dram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } dram_state_e;

  // Byte offset within a 32-byte line.
  localparam int LINE_OFFSET_BITS = 5;

  function automatic int index_width(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

  // The latency counter is loaded with latency-1, so log2(latency) bits suffice.
  function automatic int count_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/dram_line_storage.sv
// Single-port line array with registered read data; contents are never reset.
module dram_line_storage
  import dram_pkg::*;
#(
  parameter int data_width = 256,
  parameter int mem_lines  = 512,
  localparam int IDX_W     = index_width(mem_lines)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [IDX_W-1:0]      idx,
  input  logic [data_width-1:0] wdata,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem [mem_lines];

  // One access per edge: a write commits the line, a read refreshes rdata.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dram_line_responder.sv
// Memory-side responder: one line read/write per cs assertion, fixed latency, one-cycle ack.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for mem_cs; request registers load on acceptance
//   BUSY    | latency countdown; storage access on the edge leaving BUSY
//   ACK     | mem_ack high for exactly one cycle
//   RELEASE | ack delivered, waiting for the initiator to drop mem_cs
module dram_line_responder
  import dram_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int data_width = 256,
  parameter int mem_lines  = 512,
  parameter int latency    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addr_width-1:0] mem_addr,
  input  logic                  mem_cs,
  input  logic                  mem_we,
  input  logic [data_width-1:0] mem_data_i,
  output logic                  mem_ack,
  output logic [data_width-1:0] mem_data_o
);

  localparam int IDX_W = index_width(mem_lines);
  localparam int CNT_W = count_width(latency);
  // Counting down from latency-1 to zero puts the access edge exactly latency edges after acceptance.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(latency - 1);

  dram_state_e           state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      req_idx;
  logic                  req_we;
  logic [data_width-1:0] req_data;
  logic [data_width-1:0] rd_q;
  logic                  rd_valid;
  logic                  accept;
  logic                  st_we;
  logic                  st_re;
  logic                  unused_addr;

  // Line offset and bits above the index do not select a line.
  assign unused_addr = ^{mem_addr[addr_width-1:LINE_OFFSET_BITS+IDX_W],
                         mem_addr[LINE_OFFSET_BITS-1:0]};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, ack and storage strobes.
  always_comb begin
    state_nxt = state;
    mem_ack   = 1'b0;
    accept    = 1'b0;
    st_we     = 1'b0;
    st_re     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_cs) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          st_we     = req_we;
          st_re     = !req_we;
          state_nxt = ACK;
        end
      end
      ACK: begin
        mem_ack   = 1'b1;
        state_nxt = mem_cs ? RELEASE : IDLE;
      end
      RELEASE: begin
        if (!mem_cs) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latency down-counter; inputs are ignored once the request is latched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      req_idx <= '0;
      req_we  <= 1'b0;
    end else if (accept) begin
      cnt     <= CNT_LOAD;
      req_idx <= mem_addr[LINE_OFFSET_BITS +: IDX_W];
      req_we  <= mem_we;
    end else if (state == BUSY && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Write line captured at acceptance; no reset needed on the wide datapath.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_data <= mem_data_i;
    end
  end

  // Read data reads as zero until the first read completes after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
    end else if (st_re) begin
      rd_valid <= 1'b1;
    end
  end

  assign mem_data_o = rd_valid ? rd_q : '0;

  dram_line_storage #(
    .data_width(data_width),
    .mem_lines (mem_lines)
  ) u_storage (
    .clk  (clk),
    .we   (st_we),
    .re   (st_re),
    .idx  (req_idx),
    .wdata(req_data),
    .rdata(rd_q)
  );

endmodule

// File: tb/tb_dram_line_responder.sv
// Self-checking bench: table vectors, corner sequences and randomized traffic for two latency builds.
module tb_dram_line_responder;

  localparam int DW = 256;
  localparam logic [DW-1:0] P_DB = {8{32'hDEAD_BEEF}};
  localparam logic [DW-1:0] P_A  = {4{64'hA5A5_0001_5A5A_0002}};
  localparam logic [DW-1:0] P_B  = {8{32'hBBBB_0B0B}};
  localparam logic [DW-1:0] P_C  = {8{32'hC0DE_C0DE}};
  localparam logic [DW-1:0] P_D  = {16{16'hD00D}};
  localparam logic [DW-1:0] P_E  = {8{32'h0E0E_E0E0}};
  localparam logic [DW-1:0] P_F  = {8{32'hF00D_FACE}};
  localparam logic [DW-1:0] P_J  = {8{32'h1BAD_1BAD}};

  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_o;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs0, we0, ack0, cs1, we1, ack1;
  logic [31:0]   addr0, addr1;
  logic [DW-1:0] di0, di1, rdo0, rdo1;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] model [int];
  logic [DW-1:0] last_rd [2];
  vec_t          vecs [10];

  always #5 clk = ~clk;

  dram_line_responder #(.latency(10)) dut0 (
    .clk(clk), .rst(rst), .mem_addr(addr0), .mem_cs(cs0), .mem_we(we0),
    .mem_data_i(di0), .mem_ack(ack0), .mem_data_o(rdo0)
  );

  dram_line_responder #(.latency(1)) dut1 (
    .clk(clk), .rst(rst), .mem_addr(addr1), .mem_cs(cs1), .mem_we(we1),
    .mem_data_i(di1), .mem_ack(ack1), .mem_data_o(rdo1)
  );

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int mkey(input int sel, input logic [31:0] a);
    return sel * 1024 + int'((a / 32) % 512);
  endfunction

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic get_ack(input int sel);
    return (sel == 1) ? ack1 : ack0;
  endfunction

  function automatic logic [DW-1:0] get_rdo(input int sel);
    return (sel == 1) ? rdo1 : rdo0;
  endfunction

  task automatic drive(input int sel, input logic cs, input logic we, input logic [31:0] a,
                       input logic [DW-1:0] d);
    if (sel == 1) begin
      cs1 = cs; we1 = we; addr1 = a; di1 = d;
    end else begin
      cs0 = cs; we0 = we; addr0 = a; di0 = d;
    end
  endtask

  // One transaction: checks ack latency and single-cycle ack, returns mem_data_o in the ack cycle.
  task automatic do_req(input int sel, input logic we, input logic [31:0] addr,
                        input logic [DW-1:0] wdata, input int chg_cyc,
                        input logic [31:0] chg_addr, input logic [DW-1:0] chg_data,
                        output logic [DW-1:0] rd);
    int n;
    logic seen;
    int lat;
    lat  = (sel == 1) ? 1 : 10;
    n    = 0;
    seen = 1'b0;
    rd   = 'x;
    @(negedge clk);
    drive(sel, 1'b1, we, addr, wdata);
    @(posedge clk);
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == chg_cyc) drive(sel, 1'b1, we, chg_addr, chg_data);
      seen = get_ack(sel);
    end
    chk_int($sformatf("latency_dut%0d", sel), n, lat);
    if (seen) begin
      rd = get_rdo(sel);
      if (we) model[mkey(sel, addr)] = wdata;
    end
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, $urandom, P_J);
    @(posedge clk);
    #1;
    chk_int($sformatf("ack_single_dut%0d", sel), int'(get_ack(sel)), 0);
  endtask

  task automatic req_chk(input int sel, input logic we, input logic [31:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp, input string nm);
    logic [DW-1:0] rd;
    do_req(sel, we, addr, wdata, -1, 32'h0, '0, rd);
    chk_vec(nm, rd, exp);
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [DW-1:0] exp;
    logic [31:0]   a;
    int            pulses;
    int            n;
    logic          seen;
    int            sel;
    int            key;
    int            pool [6];

    vecs[0] = '{1'b1, 32'h0000_0040, P_DB, '0};
    vecs[1] = '{1'b0, 32'h0000_0040, '0,   P_DB};
    vecs[2] = '{1'b1, 32'h0000_0020, P_A,  P_DB};
    vecs[3] = '{1'b0, 32'h0000_003C, '0,   P_A};
    vecs[4] = '{1'b0, 32'h0000_4020, '0,   P_A};
    vecs[5] = '{1'b1, 32'h0000_3FE0, P_D,  P_A};
    vecs[6] = '{1'b0, 32'h0000_7FE0, '0,   P_D};
    vecs[7] = '{1'b0, 32'h0000_0040, '0,   P_DB};
    vecs[8] = '{1'b1, 32'h0000_0200, P_F,  P_DB};
    vecs[9] = '{1'b0, 32'h8000_0040, '0,   P_DB};

    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, '0);
    drive(1, 1'b0, 1'b0, 32'h0, '0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_int("reset_ack0", int'(ack0), 0);
    chk_int("reset_ack1", int'(ack1), 0);
    chk_vec("reset_data0", rdo0, '0);
    chk_vec("reset_data1", rdo1, '0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++)
      req_chk(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_o, $sformatf("vec%0d_data", i));

    // cs held 20 cycles past the ack, with write strobes that must not be taken.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h0000_0040, '0);
    @(posedge clk);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      seen = ack0;
    end
    chk_int("held_latency", n, 10);
    chk_vec("held_rdata", rdo0, P_DB);
    drive(0, 1'b1, 1'b1, 32'h0000_0040, P_J);
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ack0) pulses++;
    end
    chk_int("held_extra_acks", pulses, 0);
    chk_vec("held_data_o", rdo0, P_DB);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, '0);
    @(posedge clk);
    req_chk(0, 1'b0, 32'h0000_0040, '0, P_DB, "held_no_second_write");

    // Address/data change three cycles into a write.
    do_req(0, 1'b1, 32'h0000_0100, P_E, 3, 32'h0000_0200, P_B, rd);
    req_chk(0, 1'b0, 32'h0000_0100, '0, P_E, "busy_chg_orig_line");
    req_chk(0, 1'b0, 32'h0000_0200, '0, P_F, "busy_chg_other_line");

    // Reset five cycles into a write; the earlier committed contents must survive.
    req_chk(0, 1'b1, 32'h0000_0080, P_C, P_F, "rst_prewrite");
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h0000_0080, P_B);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_int("rst_ack", int'(ack0), 0);
    chk_vec("rst_data0", rdo0, '0);
    drive(0, 1'b0, 1'b0, 32'h0, '0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    pulses = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (ack0) pulses++;
    end
    chk_int("rst_no_ack", pulses, 0);
    @(negedge clk);
    rst = 1'b1;
    req_chk(0, 1'b0, 32'h0000_0080, '0, P_C, "rst_lost_write");
    last_rd[0] = P_C;

    // Single-cycle latency build.
    req_chk(1, 1'b1, 32'h0000_0060, P_A, '0, "lat1_write");
    req_chk(1, 1'b0, 32'h0000_0060, '0, P_A, "lat1_read");
    req_chk(1, 1'b0, 32'h0001_4075, '0, P_A, "lat1_read_wrap");
    last_rd[1] = P_A;

    // Random traffic on a pool of lines, both builds, against the line model.
    for (int i = 0; i < 6; i++) pool[i] = $urandom_range(0, 511);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 6; i++) begin
        a = 32'(pool[i]) << 5;
        req_chk(s, 1'b1, a, rnd_line(), last_rd[s], "rnd_prewrite");
      end
    end
    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 1));
      a = ($urandom & 32'hFFFF_C000) | (32'(pool[$urandom_range(0, 5)]) << 5) | 32'($urandom_range(0, 31));
      key = mkey(sel, a);
      if ($urandom_range(0, 1) == 1) begin
        req_chk(sel, 1'b1, a, rnd_line(), last_rd[sel], $sformatf("rnd%0d_write_hold", t));
      end else begin
        exp = model[key];
        req_chk(sel, 1'b0, a, '0, exp, $sformatf("rnd%0d_read", t));
        last_rd[sel] = exp;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
